// File: rtl/chr_vram_ctrl.sv
// chr_vram_ctrl: write-side controller for the character generator VRAM port.
// Arbitrates the single write port between a host single-write requester
// (fixed priority) and a screen-fill engine. Writes are only issued while
// WIN_i is high. All outputs are registered.
// Optional feature macro: CHR_VRAM_CTRL_AUTOINC_EN (adds HOST_INC_i and a
// host address cursor).
module chr_vram_ctrl #(
    parameter int C_AW = 10,
    parameter int C_DW = 8
) (
    input  logic            FSC32_CK_i,
    input  logic            XSYS_R_i,
    input  logic            WIN_i,
    input  logic            HOST_REQ_i,
    input  logic [C_AW-1:0] HOST_WAs_i,
    input  logic [C_DW-1:0] HOST_WDs_i,
`ifdef CHR_VRAM_CTRL_AUTOINC_EN
    input  logic            HOST_INC_i,
`endif
    output logic            HOST_ACK_o,
    input  logic            FILL_REQ_i,
    input  logic [C_DW-1:0] FILL_CHRs_i,
    output logic            FILL_BUSY_o,
    output logic            FILL_DONE_o,
    output logic            VRAM_WE_o,
    output logic [C_AW-1:0] VRAM_WAs_o,
    output logic [C_DW-1:0] VRAM_WDs_o,
    output logic            CPU_USE_o
);

    typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

    localparam logic [C_AW-1:0] CNT_LAST = '1;

    state_t          state, state_nxt;
    logic [C_AW-1:0] cnt;
    logic [C_DW-1:0] fill_chr;
    logic [C_AW-1:0] host_wa;
    logic            host_acc, fill_wr, fill_last;

    // next values of the registered outputs
    logic            we_d, ack_d, busy_d, done_d, cpu_d;
    logic [C_AW-1:0] wa_d;
    logic [C_DW-1:0] wd_d;

    // Host accept excludes the ACK cycle so a held REQ cannot issue twice.
    assign host_acc  = HOST_REQ_i & WIN_i & ~HOST_ACK_o;
    // Fill writes only when the host does not take the slot; the counter
    // simply stalls on a host cycle so no fill address is skipped.
    assign fill_wr   = (state == S_FILL) & WIN_i & ~host_acc;
    assign fill_last = fill_wr & (cnt == CNT_LAST);

`ifdef CHR_VRAM_CTRL_AUTOINC_EN
    logic [C_AW-1:0] cursor;

    assign host_wa = HOST_INC_i ? cursor : HOST_WAs_i;

    // Cursor follows the last accepted host address; the fill never moves it.
    always_ff @(posedge FSC32_CK_i or negedge XSYS_R_i) begin
        if (!XSYS_R_i)     cursor <= '0;
        else if (host_acc) cursor <= host_wa + 1'b1;
    end
`else
    assign host_wa = HOST_WAs_i;
`endif

    // State register.
    always_ff @(posedge FSC32_CK_i or negedge XSYS_R_i) begin
        if (!XSYS_R_i) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // Next state: start on FILL_REQ in IDLE, leave on the last fill write.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (FILL_REQ_i) state_nxt = S_FILL;
            S_FILL:  if (fill_last)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Fill counter and latched fill character; counter wraps to 0 after the last write.
    always_ff @(posedge FSC32_CK_i or negedge XSYS_R_i) begin
        if (!XSYS_R_i) begin
            cnt      <= '0;
            fill_chr <= '0;
        end else if (state == S_IDLE && FILL_REQ_i) begin
            cnt      <= '0;
            fill_chr <= FILL_CHRs_i;
        end else if (fill_wr) begin
            cnt      <= cnt + 1'b1;
        end
    end

    // Output decode: host wins the write slot, otherwise the fill engine.
    always_comb begin
        we_d   = host_acc | fill_wr;
        wa_d   = VRAM_WAs_o;
        wd_d   = VRAM_WDs_o;
        ack_d  = host_acc;
        busy_d = (state_nxt == S_FILL);
        done_d = fill_last;
        cpu_d  = (state == S_FILL) | HOST_REQ_i | HOST_ACK_o;
        if (host_acc) begin
            wa_d = host_wa;
            wd_d = HOST_WDs_i;
        end else if (fill_wr) begin
            wa_d = cnt;
            wd_d = fill_chr;
        end
    end

    // Output registers; address/data hold their last value between writes.
    always_ff @(posedge FSC32_CK_i or negedge XSYS_R_i) begin
        if (!XSYS_R_i) begin
            VRAM_WE_o   <= 1'b0;
            VRAM_WAs_o  <= '0;
            VRAM_WDs_o  <= '0;
            HOST_ACK_o  <= 1'b0;
            FILL_BUSY_o <= 1'b0;
            FILL_DONE_o <= 1'b0;
            CPU_USE_o   <= 1'b0;
        end else begin
            VRAM_WE_o   <= we_d;
            VRAM_WAs_o  <= wa_d;
            VRAM_WDs_o  <= wd_d;
            HOST_ACK_o  <= ack_d;
            FILL_BUSY_o <= busy_d;
            FILL_DONE_o <= done_d;
            CPU_USE_o   <= cpu_d;
        end
    end

endmodule

// File: tb/tb_chr_vram_ctrl.sv
// tb_chr_vram_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level reference model of the controller.
module tb_chr_vram_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          win = 1'b0, req = 1'b0, freq = 1'b0;
    logic [AW-1:0] wa = '0;
    logic [DW-1:0] wd = '0, fchr = '0;
`ifdef CHR_VRAM_CTRL_AUTOINC_EN
    logic          inc = 1'b0;
`endif

    logic          ack_o, busy_o, done_o, we_o, cpu_o;
    logic [AW-1:0] wa_o;
    logic [DW-1:0] wd_o;

    always #5 clk = ~clk;

    chr_vram_ctrl #(.C_AW(AW), .C_DW(DW)) dut (
        .FSC32_CK_i (clk),
        .XSYS_R_i   (rst_n),
        .WIN_i      (win),
        .HOST_REQ_i (req),
        .HOST_WAs_i (wa),
        .HOST_WDs_i (wd),
`ifdef CHR_VRAM_CTRL_AUTOINC_EN
        .HOST_INC_i (inc),
`endif
        .HOST_ACK_o (ack_o),
        .FILL_REQ_i (freq),
        .FILL_CHRs_i(fchr),
        .FILL_BUSY_o(busy_o),
        .FILL_DONE_o(done_o),
        .VRAM_WE_o  (we_o),
        .VRAM_WAs_o (wa_o),
        .VRAM_WDs_o (wd_o),
        .CPU_USE_o  (cpu_o)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: fill progress as an integer pointer 0..DEPTH,
    // host address cursor as an integer modulo DEPTH.
    bit            m_fill;
    int            m_ptr, m_cur;
    logic [DW-1:0] m_chr;
    logic          e_we, e_ack, e_busy, e_done, e_cpu;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;
    int            obs_fill_cnt;
    logic [AW-1:0] ack_addr_q[$];

    task automatic model_reset();
        m_fill = 0; m_ptr = 0; m_cur = 0; m_chr = '0;
        e_we = 0; e_ack = 0; e_busy = 0; e_done = 0; e_cpu = 0;
        e_wa = '0; e_wd = '0;
    endtask

    task automatic model_edge();
        bit acc, fw;
        int addr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc  = req && win && !e_ack;
        fw   = m_fill && win && !acc;
        addr = int'(wa);
`ifdef CHR_VRAM_CTRL_AUTOINC_EN
        if (inc) addr = m_cur;
`endif
        e_cpu  = m_fill || req || e_ack;
        e_we   = acc || fw;
        e_ack  = acc;
        e_done = 0;
        if (acc) begin
            e_wa  = AW'(addr);
            e_wd  = wd;
            m_cur = (addr + 1) % DEPTH;
        end else if (fw) begin
            e_wa = AW'(m_ptr);
            e_wd = m_chr;
        end
        if (fw) begin
            m_ptr++;
            if (m_ptr == DEPTH) begin
                m_ptr  = 0;
                m_fill = 0;
                e_done = 1;
            end
        end else if (!m_fill && freq) begin
            m_fill = 1;
            m_ptr  = 0;
            m_chr  = fchr;
        end
        e_busy = m_fill;
    endtask

    task automatic check_outs();
        chk("we",   we_o,   e_we);
        chk("wa",   wa_o,   e_wa);
        chk("wd",   wd_o,   e_wd);
        chk("ack",  ack_o,  e_ack);
        chk("busy", busy_o, e_busy);
        chk("done", done_o, e_done);
        chk("cpu",  cpu_o,  e_cpu);
    endtask

    // One clock: model at the rising edge, DUT checked at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outs();
        if (we_o && !ack_o) obs_fill_cnt++;
        if (ack_o) ack_addr_q.push_back(wa_o);
    endtask

    task automatic start_fill(input logic [DW-1:0] c);
        fchr = c; freq = 1'b1; obs_fill_cnt = 0;
        step();
        freq = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_o) begin seen = 1; break; end
        end
        chk("done_seen", seen, 1);
    endtask

    initial begin
        int n;
        model_reset();
        obs_fill_cnt = 0;
        #1;
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Reset mid-fill, then restart from address 0.
        win = 1'b1;
        start_fill(8'h20);
        for (int i = 0; i < 200 && obs_fill_cnt < 100; i++) step();
        chk("pre_rst_cnt", obs_fill_cnt, 100);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        step();
        rst_n = 1'b1;
        start_fill(8'h20);
        step();
        chk("restart_we", we_o, 1);
        chk("restart_addr", wa_o, 0);
        chk("restart_data", wd_o, 8'h20);
        wait_done(2 * DEPTH);

        // Full fill with WIN constantly high.
        step();
        start_fill(8'h41);
        wait_done(2 * DEPTH);
        chk("full_len", obs_fill_cnt, DEPTH);
        chk("full_last_we", we_o, 1);
        chk("full_last_addr", wa_o, DEPTH - 1);
        chk("full_last_busy", busy_o, 0);

        // Window gating, 8 high / 8 low.
        start_fill(8'h55);
        begin
            bit seen = 0;
            for (int c = 0; c < 4 * DEPTH && !seen; c++) begin
                win = ((c / 8) % 2) == 0;
                step();
                seen = done_o;
            end
            chk("gate_done_seen", seen, 1);
        end
        chk("gate_len", obs_fill_cnt, DEPTH);
        win = 1'b1;

        // Host priority inside a fill at counter 3.
        start_fill(8'h33);
        for (int i = 0; i < 20 && !(we_o && !ack_o && wa_o == 10'd2); i++) step();
        req = 1'b1; wa = 10'h005; wd = 8'h7E;
        step();
        chk("hp_ack", ack_o, 1);
        chk("hp_addr", wa_o, 10'h005);
        chk("hp_data", wd_o, 8'h7E);
        req = 1'b0;
        step();
        chk("hp_next_addr", wa_o, 3);
        wait_done(2 * DEPTH);
        chk("hp_len", obs_fill_cnt, DEPTH);

        // Host handshake in IDLE: held REQ issues every second cycle.
        req = 1'b1; wa = 10'h123; wd = 8'hA5;
        n = 0;
        for (int i = 0; i < 8; i++) begin step(); if (ack_o) n++; end
        chk("hs_acks", n, 4);
        win = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin step(); if (ack_o) n++; end
        chk("hs_noack", n, 0);
        chk("hs_cpu_use", cpu_o, 1);
        req = 1'b0; win = 1'b1;
        step(); step();

`ifdef CHR_VRAM_CTRL_AUTOINC_EN
        // Auto-increment: 0x3FF then two cursor writes wrapping to 0, 1.
        ack_addr_q.delete();
        req = 1'b1; inc = 1'b0; wa = 10'h3FF; wd = 8'h01;
        for (int i = 0; i < 20 && ack_addr_q.size() < 3; i++) begin
            step();
            if (ack_o) begin inc = 1'b1; wa = 10'h155; end
        end
        req = 1'b0; inc = 1'b0;
        chk("ai_cnt", ack_addr_q.size(), 3);
        if (ack_addr_q.size() == 3) begin
            chk("ai_a0", ack_addr_q[0], 10'h3FF);
            chk("ai_a1", ack_addr_q[1], 10'h000);
            chk("ai_a2", ack_addr_q[2], 10'h001);
        end
        step(); step();
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 6000; c++) begin
            win  = ($urandom % 4) != 0;
            freq = ($urandom % 300) == 0;
            fchr = DW'($urandom);
            if (req && ack_o) begin
                req = ($urandom % 2) == 0;
            end else if (!req) begin
                req = ($urandom % 6) == 0;
                wa  = AW'($urandom);
                wd  = DW'($urandom);
`ifdef CHR_VRAM_CTRL_AUTOINC_EN
                inc = ($urandom % 2) == 0;
`endif
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
